// File: rtl/muldiv_seq.sv
// Sequential shift-add multiplier / restoring divider covering the RISC-V M funct3 set.
// Define MULDIV_TWO_CYCLE_PER_BIT_EN to split each ITER bit into an add/trial cycle and a shift cycle.
module muldiv_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         busy
);

    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    p_q, p_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    result_q, result_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q, neg_d;
    logic            div0_q, div0_d;
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
    logic            phase_q, phase_d;
    logic [W:0]      acc_q, acc_d;
`endif

    logic            is_div;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum, r_sh, trial, div_acc, step_acc, shift_acc;
    logic [W-1:0]    shift_p, shift_m;
    logic [2*W-1:0]  prod, prod_c;
    logic [W-1:0]    quo_c, rem_c, fix_res;

    assign is_div   = op_q[2];
    assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    assign b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    assign a_neg    = a_signed & opa_q[W-1];
    assign b_neg    = b_signed & opb_q[W-1];
    assign a_mag    = a_neg ? -opa_q : opa_q;
    assign b_mag    = b_neg ? -opb_q : opb_q;

    // P/R share p_q and M/Q share m_q; step_acc carries the add or trial outcome
    // in W+1 bits so the shift can be taken the same cycle or the next.
    assign mul_sum  = {1'b0, p_q} + {1'b0, (m_q[0] ? opb_q : '0)};
    assign r_sh     = {p_q, m_q[W-1]};
    assign trial    = r_sh - {1'b0, opb_q};
    assign div_acc  = trial[W] ? {1'b0, r_sh[W-1:0]} : {1'b1, trial[W-1:0]};
    assign step_acc = is_div ? div_acc : mul_sum;
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
    assign shift_acc = acc_q;
`else
    assign shift_acc = step_acc;
`endif
    assign shift_p  = is_div ? shift_acc[W-1:0] : shift_acc[W:1];
    assign shift_m  = is_div ? {m_q[W-2:0], shift_acc[W]} : {shift_acc[0], m_q[W-1:1]};

    assign prod     = {p_q, m_q};
    assign prod_c   = neg_q ? -prod : prod;
    assign quo_c    = neg_q ? -m_q : m_q;
    assign rem_c    = neg_q ? -p_q : p_q;

    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:                        fix_res = prod_c[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_c[2*W-1:W];
            OP_DIV, OP_DIVU:               fix_res = div0_q ? '1 : quo_c;
            OP_REM, OP_REMU:               fix_res = div0_q ? opa_q : rem_c;
            default:                       fix_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        p_d      = p_q;
        m_d      = m_q;
        result_d = result_q;
        count_d  = count_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
        phase_d  = phase_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    opa_d   = a;
                    opb_d   = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                opb_d   = b_mag;
                m_d     = a_mag;
                p_d     = '0;
                neg_d   = (op_q[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
                div0_d  = (opb_q == '0);
                count_d = CW'(W - 1);
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
                phase_d = 1'b0;
`endif
                state_d = S_ITER;
            end
            S_ITER: begin
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
                if (!phase_q) begin
                    acc_d   = step_acc;
                    phase_d = 1'b1;
                end else begin
                    p_d     = shift_p;
                    m_d     = shift_m;
                    phase_d = 1'b0;
                    if (count_q == '0) state_d = S_FIX;
                    else               count_d = count_q - CW'(1);
                end
`else
                p_d = shift_p;
                m_d = shift_m;
                if (count_q == '0) state_d = S_FIX;
                else               count_d = count_q - CW'(1);
`endif
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
            phase_q  <= 1'b0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            p_q      <= p_d;
            m_q      <= m_d;
            result_q <= result_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
            phase_q  <= phase_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq at W=8: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_seq;
    localparam int W = 8;
`ifdef MULDIV_TWO_CYCLE_PER_BIT_EN
    localparam longint LAT = 2 * W + 2;
`else
    localparam longint LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         busy;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     mode = 0;   // 0: out_ready high, 1: random, 2: held low

    typedef struct {
        logic [W-1:0] res;
        longint       acc;
        string        name;
    } exp_t;
    exp_t q[$];

    string opn[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

    muldiv_seq #(.W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W-1:0] xs, ys;
        longint sx, sy, ux, uy, p;
        xs = x; ys = y;
        sx = longint'(xs); sy = longint'(ys);
        ux = longint'(x);  uy = longint'(y);
        case (o)
            3'd0: p = ux * uy;
            3'd1: p = (sx * sy) >>> W;
            3'd2: p = (sx * uy) >>> W;
            3'd3: p = (ux * uy) >> W;
            3'd4: p = (y == '0) ? -1 : sx / sy;
            3'd5: p = (y == '0) ? -1 : ux / uy;
            3'd6: p = (y == '0) ? ux : sx % sy;
            default: p = (y == '0) ? ux : ux % uy;
        endcase
        return W'(p);
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom % 6)
            0: v = '0;
            1: v = '1;
            2: begin v = '0; v[W-1] = 1'b1; end
            3: v = W'(1);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Called and returns at posedge+#1.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] exp, input string nm);
        int n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 400) begin
                checks++; failures++;
                $display("FAIL %s_accept in_ready=0 required=1 (timeout)", nm);
                return;
            end
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back('{exp, cyc, nm});
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            out_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor: first valid cycle checks latency and value, later held cycles check stability.
    initial begin
        bit seen = 0;
        logic [W-1:0] held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                seen = 0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output actual=0x%0h required=none", result);
                    end else begin
                        check({q[0].name, "_latency"}, 64'(cyc - q[0].acc), 64'(LAT));
                        check({q[0].name, "_result"}, 64'(result), 64'(q[0].res));
                        held = result;
                        seen = 1;
                    end
                end else begin
                    check("hold_result", 64'(result), 64'(held));
                    check("hold_in_ready", 64'(in_ready), 64'(0));
                    check("hold_busy", 64'(busy), 64'(1));
                end
                if (out_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 8'hFF, 8'h02, 8'hFE, "MUL_ff_02");
        issue(3'd1, 8'hFF, 8'h02, 8'hFF, "MULH_ff_02");
        issue(3'd3, 8'hFF, 8'h02, 8'h01, "MULHU_ff_02");
        issue(3'd2, 8'hFF, 8'h02, 8'hFF, "MULHSU_ff_02");
        issue(3'd4, 8'hF9, 8'h02, 8'hFD, "DIV_f9_02");
        issue(3'd6, 8'hF9, 8'h02, 8'hFF, "REM_f9_02");
        issue(3'd5, 8'hF9, 8'h02, 8'h7C, "DIVU_f9_02");
        issue(3'd7, 8'hF9, 8'h02, 8'h01, "REMU_f9_02");
        issue(3'd4, 8'h05, 8'h00, 8'hFF, "DIV_by0");
        issue(3'd5, 8'h05, 8'h00, 8'hFF, "DIVU_by0");
        issue(3'd6, 8'h05, 8'h00, 8'h05, "REM_by0");
        issue(3'd7, 8'h05, 8'h00, 8'h05, "REMU_by0");
        issue(3'd4, 8'h80, 8'hFF, 8'h80, "DIV_ovf");
        issue(3'd6, 8'h80, 8'hFF, 8'h00, "REM_ovf");

        // Backpressure with junk requests pulsed while busy.
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        mode = 2;
        @(posedge clk); #1;
        issue(3'd1, 8'h9C, 8'h37, model(3'd1, 8'h9C, 8'h37), "MULH_bp");
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = 1'($urandom % 2); op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            checks++; failures++;
            $display("FAIL bp_out_valid actual=0 required=1 (timeout)");
        end
        repeat (5) begin
            in_valid = 1'($urandom % 2); op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        mode = 0;
        @(posedge clk); #1;
        check("bp_release_out_valid", 64'(out_valid), 64'(0));
        check("bp_release_in_ready", 64'(in_ready), 64'(1));

        // Reset during the third ITER cycle.
        issue(3'd0, 8'h55, 8'h23, model(3'd0, 8'h55, 8'h23), "MUL_aborted");
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rstn = 1'b0;
        void'(q.pop_back());
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_result", 64'(result), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        @(posedge clk); #3 rstn = 1'b1;
        @(posedge clk); #1;
        issue(3'd0, 8'h03, 8'h05, 8'h0F, "MUL_after_reset");

        mode = 1;
        for (int i = 0; i < 80; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom);
            ra = rnd_operand();
            rb = rnd_operand();
            issue(ro, ra, rb, model(ro, ra, rb), $sformatf("%s_%02h_%02h", opn[ro], ra, rb));
        end

        n = 0;
        while (q.size() > 0 && n < 2000) begin @(posedge clk); n++; end
        if (q.size() > 0) begin
            checks++; failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        mode = 0;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
